pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 128, meaning payload width in bits (legal range 1-1024).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning transfer-counter width in bits (legal range 1-32).
REQ-003 SHALL provide port CLK  input  1  meaning single clock; all state updates on the rising edge.
REQ-004 SHALL provide port RESETn  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL provide port Stall  input  1  meaning global hold (cache stall); freezes the stage.
REQ-006 SHALL provide port Flush  input  1  meaning discard all held entries.
REQ-007 SHALL provide port in_valid  input  1  meaning upstream entry present.
REQ-008 SHALL provide port in_data  input  DATA_W  meaning upstream payload.
REQ-009 SHALL provide port in_ready  output  1  meaning stage accepts an entry this cycle.
REQ-010 SHALL provide port out_valid  output  1  meaning downstream entry present.
REQ-011 SHALL provide port out_data  output  DATA_W  meaning downstream payload.
REQ-012 SHALL provide port out_ready  input  1  meaning downstream accepts an entry.
REQ-013 SHALL provide port occupancy  output  2  meaning number of held entries (0-2).
REQ-014 SHALL provide port xfer_count  output  CNT_W  meaning number of completed output transfers.

Function
REQ-015 SHALL hold up to two entries: main register (drives out_data) and skid register.
REQ-016 SHALL implement three states: EMPTY (occupancy 0), ONE (1), FULL (2).
REQ-017 SHALL drive in_ready = !Stall && !Flush && state != FULL, combinationally.
REQ-018 SHALL drive out_valid = (state != EMPTY), registered, independent of Stall.
REQ-019 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready && !Stall && !Flush.
REQ-020 SHALL, in EMPTY on push, load main from in_data and go to ONE.
REQ-021 SHALL, in ONE on push and pop, load main from in_data and stay in ONE (zero-bubble throughput).
REQ-022 SHALL, in ONE on push without pop, load skid from in_data and go to FULL.
REQ-023 SHALL, in ONE on pop without push, go to EMPTY.
REQ-024 SHALL, in FULL on pop, move skid into main and go to ONE; no push occurs in FULL.
REQ-025 SHALL, with no push and no pop, keep state, main and skid unchanged.
REQ-026 SHALL preserve FIFO order: entries leave in acceptance order, none duplicated or dropped except by Flush.
REQ-027 SHALL, while Stall=1, hold state, main, skid, out_valid, out_data and xfer_count unchanged regardless of in_valid/out_ready.
REQ-028 SHALL, on Flush=1 at a clock edge, go to EMPTY and accept no push; Flush overrides Stall, push and pop.
REQ-029 SHALL leave main/skid payload contents unchanged on Flush; out_data is don't-care while out_valid=0.
REQ-030 SHALL increment xfer_count by 1 on every pop, wrapping from 2^CNT_W-1 to 0.
REQ-031 SHALL present data with one-cycle latency: an entry pushed at edge N is visible on out_data after edge N when the stage was EMPTY or popping.

Reset
REQ-032 SHALL, while RESETn=0, asynchronously force state EMPTY, occupancy 0, out_valid 0, out_data 0, skid 0, xfer_count 0.
REQ-033 SHALL, with RESETn low, drive in_ready = !Stall && !Flush (state EMPTY).
REQ-034 SHALL, on reset assertion mid-transfer, discard all held entries; the first edge after RESETn rises behaves as state EMPTY.

Verification
REQ-035 SHALL cover streaming: in_valid=1, out_ready=1 every cycle, data 0x1,0x2,0x3 -> out_data 0x1,0x2,0x3 on consecutive cycles, occupancy stays 1, xfer_count=3.
REQ-036 SHALL cover backpressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0; out_ready=1 -> 0xA then 0xB delivered in order.
REQ-037 SHALL cover stall: FULL with 0xA/0xB, Stall=1 for 3 cycles with out_ready=1 -> out_data=0xA, occupancy=2, xfer_count unchanged, in_ready=0.
REQ-038 SHALL cover flush: FULL, Flush=1 with Stall=1 and in_valid=1 -> next cycle occupancy 0, out_valid 0, in_ready=1 after Flush drops.
REQ-039 SHALL cover counter wrap: CNT_W=2, 5 pops -> xfer_count sequence 1,2,3,0,1.
REQ-040 SHALL cover async reset: assert RESETn=0 mid-cycle while FULL -> out_valid=0, occupancy=0, xfer_count=0 before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Two-entry skid-buffered pipeline register with stall, flush and
//            a wrapping completed-transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              w_push;
  logic              w_pop;

  // Stall and Flush gate both handshakes, so the FSM below never needs to
  // look at Stall directly.
  assign in_ready = !Stall && !Flush && (state_q != S_FULL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid_q && out_ready && !Stall && !Flush;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else if (Flush) begin
      // Payload registers keep their contents; only occupancy is discarded.
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      if (w_pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_EMPTY: begin
          if (w_push) begin
            main_q      <= in_data;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            main_q <= in_data;
          end else if (w_push) begin
            skid_q  <= in_data;
            state_q <= S_FULL;
          end else if (w_pop) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            main_q  <= skid_q;
            state_q <= S_ONE;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = main_q;
  assign occupancy  = state_q;
  assign xfer_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed, table-driven self-checking bench for pipe_stage_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          Stall;
  logic          Flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [CW-1:0] xfer_count;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .Stall      (Stall),
    .Flush      (Flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .xfer_count (xfer_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          stall;
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_dat;
    logic [1:0]    e_occ;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic stall, input logic flush, input logic iv,
                              input logic [DW-1:0] d, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [DW-1:0] e_dat,
                              input logic [1:0] e_occ, input logic [CW-1:0] e_cnt);
    vec_t v;
    v.stall = stall; v.flush = flush; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_dat = e_dat; v.e_occ = e_occ; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic flush, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
    @(negedge CLK);
    Stall = stall; Flush = flush; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic step(input logic stall, input logic flush, input logic iv,
                      input logic [DW-1:0] d, input logic ordy);
    drive(stall, flush, iv, d, ordy);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn = 1'b0; Stall = 1'b0; Flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  initial begin
    RESETn = 1'b0; Stall = 1'b0; Flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //           st fl iv d       or  ir ov dat     occ cnt
    // streaming
    vecs.push_back(mk(0, 0, 1, 16'h1, 1, 1, 1, 16'h1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h2, 1, 1, 1, 16'h2, 1, 1));
    vecs.push_back(mk(0, 0, 1, 16'h3, 1, 1, 1, 16'h3, 1, 2));
    vecs.push_back(mk(0, 0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 3));
    // backpressure, then drain in order (counter wraps 3 -> 0)
    vecs.push_back(mk(0, 0, 1, 16'hA, 0, 1, 1, 16'hA, 1, 3));
    vecs.push_back(mk(0, 0, 1, 16'hB, 0, 1, 1, 16'hA, 2, 3));
    vecs.push_back(mk(0, 0, 1, 16'hC, 0, 0, 1, 16'hA, 2, 3));
    vecs.push_back(mk(0, 0, 0, 16'h0, 1, 0, 1, 16'hB, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 1));
    // stall while FULL for three cycles
    vecs.push_back(mk(0, 0, 1, 16'hA, 0, 1, 1, 16'hA, 1, 1));
    vecs.push_back(mk(0, 0, 1, 16'hB, 0, 1, 1, 16'hA, 2, 1));
    vecs.push_back(mk(1, 0, 1, 16'hC, 1, 0, 1, 16'hA, 2, 1));
    vecs.push_back(mk(1, 0, 1, 16'hC, 1, 0, 1, 16'hA, 2, 1));
    vecs.push_back(mk(1, 0, 1, 16'hC, 1, 0, 1, 16'hA, 2, 1));
    vecs.push_back(mk(0, 0, 1, 16'hD, 1, 0, 1, 16'hB, 1, 2));
    vecs.push_back(mk(0, 0, 1, 16'hE, 1, 1, 1, 16'hE, 1, 3));
    vecs.push_back(mk(1, 0, 1, 16'hF, 1, 0, 1, 16'hE, 1, 3));
    // flush overriding stall and push while FULL
    vecs.push_back(mk(0, 0, 1, 16'h7, 0, 1, 1, 16'hE, 2, 3));
    vecs.push_back(mk(1, 1, 1, 16'h9, 1, 0, 0, 16'h0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 16'h0, 0, 1, 0, 16'h0, 0, 3));
    // flush blocks a pop in ONE; skid leftovers must not resurface
    vecs.push_back(mk(0, 0, 1, 16'h5, 1, 1, 1, 16'h5, 1, 3));
    vecs.push_back(mk(0, 1, 1, 16'h8, 1, 0, 0, 16'h0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 16'h6, 1, 1, 1, 16'h6, 1, 3));
    vecs.push_back(mk(0, 0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 0));

    do_reset();
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst occupancy", occupancy, 0);
    chk("rst xfer_count", xfer_count, 0);
    chk("rst out_data", out_data, 0);
    chk("rst in_ready", in_ready, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_ir);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d occupancy", i), occupancy, vecs[i].e_occ);
      chk($sformatf("v%0d xfer_count", i), xfer_count, vecs[i].e_cnt);
      if (vecs[i].e_ov) chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_dat);
    end

    // Counter wrap: five pops from reset give 1,2,3,0,1
    do_reset();
    step(0, 0, 1, 16'h11, 1);
    chk("wrap prime cnt", xfer_count, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, DW'(16'h12 + k), 1);
      chk($sformatf("wrap%0d cnt", k), xfer_count, (k + 1) % 4);
      chk($sformatf("wrap%0d data", k), out_data, 16'h12 + k);
      chk($sformatf("wrap%0d occ", k), occupancy, 1);
    end

    // Async reset mid-cycle while FULL (count is 1 beforehand)
    step(0, 0, 1, 16'hA, 0);
    step(0, 0, 1, 16'hB, 0);
    chk("pre-arst occ", occupancy, 2);
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst occupancy", occupancy, 0);
    chk("arst xfer_count", xfer_count, 0);
    chk("arst out_data", out_data, 0);
    chk("arst in_ready", in_ready, 1);
    Stall = 1'b1;
    #1;
    chk("arst in_ready stall", in_ready, 0);
    Stall = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    step(0, 0, 1, 16'h33, 0);
    chk("post-arst occ", occupancy, 1);
    chk("post-arst data", out_data, 16'h33);
    step(0, 0, 0, 16'h0, 1);
    chk("post-arst drain occ", occupancy, 0);
    chk("post-arst drain ov", out_valid, 0);
    chk("post-arst drain cnt", xfer_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
